line_buf_ctrl: RTL and testbench

LINE_BUF_CTRL -- requirements
Module: line_buf_ctrl

---
 rtl/line_buf_ctrl.sv | 163 ++++++++++++++++
 tb/tb_line_buf_ctrl.sv | 392 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/line_buf_ctrl.sv
// Line-buffer controller: streams a binary image through two row FIFOs
// and emits one 3-row window column per accepted pixel.
module line_buf_ctrl #(
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sof,
    input  logic        pix_vld,
    input  logic        pix_data,
    output logic        pix_rdy,
    output logic        lb0_wr_en,
    output logic        lb0_wr_data,
    output logic        lb0_rd_en,
    output logic        lb1_wr_en,
    output logic        lb1_wr_data,
    output logic        lb1_rd_en,
    input  logic        lb0_rd_data,
    input  logic        lb0_empty,
    input  logic        lb0_full,
    input  logic        lb1_rd_data,
    input  logic        lb1_empty,
    input  logic        lb1_full,
    output logic        win_vld,
    output logic [2:0]  win_col,
    output logic [11:0] win_x,
    output logic [11:0] win_y,
    output logic        frame_done,
    output logic        ovf_err,
    output logic        sync_err
);

    typedef enum logic [2:0] {
        IDLE, ROW0, ROW1, STREAM, FLUSH
    } state_t;

    localparam logic [11:0] X_LAST = 12'(IMG_WIDTH - 1);
    localparam logic [11:0] Y_LAST = 12'(IMG_HEIGHT - 1);

    state_t      state_q, state_d, p_st_q;
    logic [11:0] x_q, y_q, p_x_q, p_y_q;
    logic        p_vld_q, p_pix_q;
    logic        ovf_q, sync_q, abort_q;

    logic running, accept, line_end;
    logic flush_go, flush_done;
    logic want0, want1;

    always_comb begin
        running    = (state_q == ROW0) || (state_q == ROW1)
                  || (state_q == STREAM);
        accept     = running && pix_vld && !sof;
        line_end   = accept && (x_q == X_LAST);
        // drain only after the last pipelined write has landed
        flush_go   = (state_q == FLUSH) && !p_vld_q;
        flush_done = flush_go && lb0_empty && lb1_empty;
        want0      = p_vld_q;
        want1      = p_vld_q && (p_st_q != ROW0);
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:   if (sof) state_d = ROW0;
            ROW0: begin
                if (sof)           state_d = FLUSH;
                else if (line_end) state_d = ROW1;
            end
            ROW1: begin
                if (sof)           state_d = FLUSH;
                else if (line_end) state_d = STREAM;
            end
            STREAM: begin
                if (sof)
                    state_d = FLUSH;
                else if (line_end && (y_q == Y_LAST))
                    state_d = FLUSH;
            end
            FLUSH:  if (flush_done) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        pix_rdy     = 1'b0;
        lb0_wr_en   = 1'b0;
        lb0_wr_data = 1'b0;
        lb0_rd_en   = 1'b0;
        lb1_wr_en   = 1'b0;
        lb1_wr_data = 1'b0;
        lb1_rd_en   = 1'b0;
        win_vld     = 1'b0;
        win_col     = 3'b000;
        win_x       = 12'd0;
        win_y       = 12'd0;
        frame_done  = 1'b0;
        ovf_err     = 1'b0;
        sync_err    = 1'b0;
        if (!rst) begin
            pix_rdy   = running;
            lb0_rd_en = !lb0_empty && (flush_go || (accept
                      && ((state_q == ROW1) || (state_q == STREAM))));
            lb1_rd_en = !lb1_empty && (flush_go
                      || (accept && (state_q == STREAM)));
            lb0_wr_en   = want0 && !lb0_full;
            lb0_wr_data = lb0_wr_en && p_pix_q;
            lb1_wr_en   = want1 && !lb1_full;
            lb1_wr_data = lb1_wr_en && lb0_rd_data;
            win_vld     = p_vld_q && (p_st_q == STREAM);
            if (win_vld) begin
                win_col = {lb1_rd_data, lb0_rd_data, p_pix_q};
                win_x   = p_x_q;
                win_y   = p_y_q;
            end
            frame_done = flush_done && !abort_q;
            ovf_err    = ovf_q;
            sync_err   = sync_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            x_q     <= 12'd0;
            y_q     <= 12'd0;
            p_vld_q <= 1'b0;
            p_pix_q <= 1'b0;
            p_st_q  <= IDLE;
            p_x_q   <= 12'd0;
            p_y_q   <= 12'd0;
            ovf_q   <= 1'b0;
            sync_q  <= 1'b0;
            abort_q <= 1'b0;
        end else begin
            state_q <= state_d;
            p_vld_q <= accept;
            p_pix_q <= pix_data;
            p_st_q  <= state_q;
            p_x_q   <= x_q;
            p_y_q   <= y_q;
            sync_q  <= sof && (state_q != IDLE);
            ovf_q   <= ovf_q || (want0 && lb0_full)
                    || (want1 && lb1_full);
            if ((state_q == IDLE) && sof) begin
                x_q     <= 12'd0;
                y_q     <= 12'd0;
                abort_q <= 1'b0;
            end else if (accept) begin
                if (x_q == X_LAST) begin
                    x_q <= 12'd0;
                    y_q <= y_q + 12'd1;
                end else begin
                    x_q <= x_q + 12'd1;
                end
            end
            // an aborted frame drains silently
            if (sof && running)
                abort_q <= 1'b1;
        end
    end

endmodule

// File: tb/tb_line_buf_ctrl.sv
// Bench for line_buf_ctrl: 8x4 instance with FIFO models and a
// 3-row golden model, plus a 4095-wide instance for the wrap limit.
module tb_line_buf_ctrl;

    localparam int W  = 8;
    localparam int H  = 4;
    localparam int WB = 4095;
    localparam int HB = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic sof = 1'b0, vld = 1'b0, dat = 1'b0;
    logic pix_rdy, lb0_wr_en, lb0_wr_data, lb0_rd_en;
    logic lb1_wr_en, lb1_wr_data, lb1_rd_en;
    logic lb0_rd_data, lb0_empty, lb0_full;
    logic lb1_rd_data, lb1_empty, lb1_full;
    logic win_vld, frame_done, ovf_err, sync_err;
    logic [2:0] win_col;
    logic [11:0] win_x, win_y;

    logic sof_b = 1'b0, vld_b = 1'b0, dat_b = 1'b0;
    logic b_pix_rdy, b_lb0_wr_en, b_lb0_wr_data, b_lb0_rd_en;
    logic b_lb1_wr_en, b_lb1_wr_data, b_lb1_rd_en;
    logic b_lb0_rd_data, b_lb0_empty, b_lb0_full;
    logic b_lb1_rd_data, b_lb1_empty, b_lb1_full;
    logic b_win_vld, b_frame_done, b_ovf_err, b_sync_err;
    logic [2:0] b_win_col;
    logic [11:0] b_win_x, b_win_y;

    logic force_full0 = 1'b0;
    logic [37:0] outs;
    assign outs = {pix_rdy, lb0_wr_en, lb0_wr_data, lb0_rd_en,
                   lb1_wr_en, lb1_wr_data, lb1_rd_en, win_vld,
                   win_col, win_x, win_y, frame_done, ovf_err,
                   sync_err};

    line_buf_ctrl #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
        .clk(clk), .rst(rst), .sof(sof), .pix_vld(vld),
        .pix_data(dat), .pix_rdy(pix_rdy),
        .lb0_wr_en(lb0_wr_en), .lb0_wr_data(lb0_wr_data),
        .lb0_rd_en(lb0_rd_en), .lb1_wr_en(lb1_wr_en),
        .lb1_wr_data(lb1_wr_data), .lb1_rd_en(lb1_rd_en),
        .lb0_rd_data(lb0_rd_data), .lb0_empty(lb0_empty),
        .lb0_full(lb0_full), .lb1_rd_data(lb1_rd_data),
        .lb1_empty(lb1_empty), .lb1_full(lb1_full),
        .win_vld(win_vld), .win_col(win_col), .win_x(win_x),
        .win_y(win_y), .frame_done(frame_done),
        .ovf_err(ovf_err), .sync_err(sync_err)
    );

    line_buf_ctrl #(.IMG_WIDTH(WB), .IMG_HEIGHT(HB)) dut_b (
        .clk(clk), .rst(rst), .sof(sof_b), .pix_vld(vld_b),
        .pix_data(dat_b), .pix_rdy(b_pix_rdy),
        .lb0_wr_en(b_lb0_wr_en), .lb0_wr_data(b_lb0_wr_data),
        .lb0_rd_en(b_lb0_rd_en), .lb1_wr_en(b_lb1_wr_en),
        .lb1_wr_data(b_lb1_wr_data), .lb1_rd_en(b_lb1_rd_en),
        .lb0_rd_data(b_lb0_rd_data), .lb0_empty(b_lb0_empty),
        .lb0_full(b_lb0_full), .lb1_rd_data(b_lb1_rd_data),
        .lb1_empty(b_lb1_empty), .lb1_full(b_lb1_full),
        .win_vld(b_win_vld), .win_col(b_win_col),
        .win_x(b_win_x), .win_y(b_win_y),
        .frame_done(b_frame_done), .ovf_err(b_ovf_err),
        .sync_err(b_sync_err)
    );

    // four 4096x1 FIFO models: 0/1 for dut, 2/3 for dut_b
    logic f_wr[4], f_rd[4], f_wd[4], f_q[4];
    int   fcnt[4], fwp[4], frp[4];
    logic fmem[4][4096];
    int   uf = 0;
    int   maxc2 = 0;

    assign f_wr[0] = lb0_wr_en;    assign f_wd[0] = lb0_wr_data;
    assign f_wr[1] = lb1_wr_en;    assign f_wd[1] = lb1_wr_data;
    assign f_wr[2] = b_lb0_wr_en;  assign f_wd[2] = b_lb0_wr_data;
    assign f_wr[3] = b_lb1_wr_en;  assign f_wd[3] = b_lb1_wr_data;
    assign f_rd[0] = lb0_rd_en;    assign f_rd[1] = lb1_rd_en;
    assign f_rd[2] = b_lb0_rd_en;  assign f_rd[3] = b_lb1_rd_en;
    assign lb0_rd_data   = f_q[0];
    assign lb1_rd_data   = f_q[1];
    assign b_lb0_rd_data = f_q[2];
    assign b_lb1_rd_data = f_q[3];
    assign lb0_empty   = (fcnt[0] == 0);
    assign lb1_empty   = (fcnt[1] == 0);
    assign b_lb0_empty = (fcnt[2] == 0);
    assign b_lb1_empty = (fcnt[3] == 0);
    assign lb0_full    = (fcnt[0] == 4096) || force_full0;
    assign lb1_full    = (fcnt[1] == 4096);
    assign b_lb0_full  = (fcnt[2] == 4096);
    assign b_lb1_full  = (fcnt[3] == 4096);

    always @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (rst) begin
                fcnt[i] <= 0;
                fwp[i]  <= 0;
                frp[i]  <= 0;
                f_q[i]  <= 1'b0;
            end else begin
                if (f_rd[i] && fcnt[i] == 0)
                    uf <= uf + 1;
                if (f_rd[i] && fcnt[i] > 0) begin
                    f_q[i] <= fmem[i][frp[i]];
                    frp[i] <= (frp[i] + 1) % 4096;
                end
                if (f_wr[i] && fcnt[i] < 4096) begin
                    fmem[i][fwp[i]] <= f_wd[i];
                    fwp[i] <= (fwp[i] + 1) % 4096;
                end
                fcnt[i] <= fcnt[i]
                         + ((f_wr[i] && fcnt[i] < 4096) ? 1 : 0)
                         - ((f_rd[i] && fcnt[i] > 0) ? 1 : 0);
            end
        end
        if (fcnt[2] > maxc2)
            maxc2 <= fcnt[2];
    end

    int checks = 0;
    int failures = 0;

    task automatic chk(input string nm, input longint got,
                       input longint exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", nm, got, exp);
        end
    endtask

    function automatic logic pat(input int x, input int y);
        int v;
        v = x * 13 + y * 7 + (x >> 2);
        return v[1];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // golden model for dut: tracks accepted coordinates
    int  cyc = 0;
    bit  mon_en = 0;
    bit  exp_wv = 0;
    bit  acc;
    int  m_x, m_y, ex, ey;
    int  win_cnt, done_cnt, last_acc, done_at;
    logic [2:0] gold;

    initial forever begin
        @(negedge clk);
        cyc++;
        if (mon_en) begin
            acc = vld && pix_rdy && !sof;
            chk("win_vld_lat", win_vld, exp_wv);
            if (win_vld) begin
                win_cnt++;
                gold = {pat(ex, ey - 2), pat(ex, ey - 1), pat(ex, ey)};
                chk("win_x", win_x, ex);
                chk("win_y", win_y, ey);
                chk("win_col", win_col, gold);
            end
            if (frame_done) begin
                done_cnt++;
                done_at = cyc;
            end
            exp_wv = acc && (m_y >= 2);
            ex = m_x;
            ey = m_y;
            if (acc) begin
                last_acc = cyc;
                if (m_x == W - 1) begin
                    m_x = 0;
                    m_y++;
                end else begin
                    m_x++;
                end
            end
        end
    end

    bit mon_b = 0;
    int bx = 0, maxx = 0, bwin = 0, bdone = 0;
    bit bfull = 0;
    logic [2:0] gold_b;

    initial forever begin
        @(negedge clk);
        if (mon_b) begin
            if (b_win_vld) begin
                gold_b = {pat(b_win_x, b_win_y - 2),
                          pat(b_win_x, b_win_y - 1),
                          pat(b_win_x, b_win_y)};
                chk("b_win_col", b_win_col, gold_b);
                chk("b_win_x", b_win_x, bx);
                chk("b_win_y", b_win_y, 2);
                bx++;
                bwin++;
                if (int'(b_win_x) > maxx)
                    maxx = b_win_x;
            end
            if (b_frame_done)
                bdone++;
            if (b_lb0_full)
                bfull = 1;
        end
    end

    task automatic model_start();
        m_x = 0; m_y = 0; exp_wv = 0;
        win_cnt = 0; done_cnt = 0; done_at = 0;
        mon_en = 1;
    endtask

    task automatic do_reset();
        mon_en = 0;
        rst = 1; sof = 0; vld = 0;
        tick();
        @(negedge clk);
        chk("rst_outs", outs, 0);
        tick();
        rst = 0;
        @(negedge clk);
        chk("post_rst_outs", outs, 0);
        tick();
    endtask

    task automatic run_frame(input bit gap, input int exp_win,
                             input int exp_done, input string tag);
        int n;
        n = 0;
        model_start();
        sof = 1; vld = 1; dat = 1;
        tick();
        sof = 0;
        while (n < W * H) begin
            if (gap && $urandom_range(1) == 0) begin
                vld = 0;
            end else begin
                vld = 1;
                dat = pat(n % W, n / W);
                n++;
            end
            tick();
        end
        vld = 0;
        for (int i = 0; i < 40 && done_cnt == 0; i++)
            tick();
        tick();
        tick();
        chk({tag, "_wins"}, win_cnt, exp_win);
        chk({tag, "_done"}, done_cnt, exp_done);
        chk({tag, "_done_lat"},
            (done_at - last_acc >= 6 && done_at - last_acc <= 12), 1);
        chk({tag, "_lb0_empty"}, fcnt[0], 0);
        chk({tag, "_lb1_empty"}, fcnt[1], 0);
        chk({tag, "_ovf"}, ovf_err, 0);
    endtask

    typedef struct {
        bit gap;
        int exp_win;
        int exp_done;
    } fvec_t;

    fvec_t vt[3];
    bit seen;

    initial begin
        vt[0] = '{gap: 0, exp_win: 16, exp_done: 1};
        vt[1] = '{gap: 1, exp_win: 16, exp_done: 1};
        vt[2] = '{gap: 1, exp_win: 16, exp_done: 1};

        do_reset();
        for (int k = 0; k < 3; k++)
            run_frame(vt[k].gap, vt[k].exp_win, vt[k].exp_done,
                      $sformatf("frame%0d", k));

        // sof mid-frame at y=2, x=3
        model_start();
        sof = 1; vld = 1;
        tick();
        sof = 0;
        for (int n = 0; n < 19; n++) begin
            vld = 1;
            dat = pat(n % W, n / W);
            tick();
        end
        sof = 1; vld = 1; dat = 0;
        tick();
        sof = 0; vld = 0;
        @(negedge clk);
        chk("sync_err_pulse", sync_err, 1);
        tick();
        @(negedge clk);
        chk("sync_err_clear", sync_err, 0);
        sof = 1;
        tick();
        sof = 0;
        @(negedge clk);
        chk("flush_sof_sync", sync_err, 1);
        chk("flush_sof_ignored", pix_rdy, 0);
        for (int i = 0; i < 40 && (fcnt[0] != 0 || fcnt[1] != 0); i++)
            tick();
        tick();
        tick();
        chk("abort_lb0_empty", fcnt[0], 0);
        chk("abort_lb1_empty", fcnt[1], 0);
        chk("abort_no_done", done_cnt, 0);
        chk("abort_wins", win_cnt, 3);
        chk("abort_idle_rdy", pix_rdy, 0);
        run_frame(0, 16, 1, "after_sync");

        // overflow on lb0 during ROW0
        do_reset();
        force_full0 = 1;
        model_start();
        sof = 1; vld = 1;
        tick();
        sof = 0;
        seen = 0;
        for (int i = 0; i < W; i++) begin
            vld = 1;
            dat = pat(i, 0);
            tick();
            vld = 0;
            @(negedge clk);
            seen = seen | lb0_wr_en;
        end
        tick();
        @(negedge clk);
        chk("ovf_wr_blocked", seen, 0);
        chk("ovf_set", ovf_err, 1);
        force_full0 = 0;
        tick();
        tick();
        @(negedge clk);
        chk("ovf_sticky", ovf_err, 1);
        do_reset();
        chk("ovf_cleared", ovf_err, 0);

        // reset mid-STREAM
        model_start();
        sof = 1; vld = 1;
        tick();
        sof = 0;
        for (int n = 0; n < 20; n++) begin
            vld = 1;
            dat = pat(n % W, n / W);
            tick();
        end
        mon_en = 0;
        rst = 1;
        @(negedge clk);
        chk("midrst_outs", outs, 0);
        tick();
        rst = 0; vld = 0;
        @(negedge clk);
        chk("midrst_after_outs", outs, 0);
        tick();
        run_frame(0, 16, 1, "after_rst");

        // maximum width instance
        mon_b = 1;
        sof_b = 1;
        tick();
        sof_b = 0;
        for (int n = 0; n < WB * HB; n++) begin
            vld_b = 1;
            dat_b = pat(n % WB, n / WB);
            tick();
        end
        vld_b = 0;
        for (int i = 0; i < 5000 && bdone == 0; i++)
            tick();
        tick();
        chk("b_wins", bwin, WB);
        chk("b_max_x", maxx, WB - 1);
        chk("b_done", bdone, 1);
        chk("b_lb0_peak", maxc2, WB);
        chk("b_no_full", bfull, 0);
        chk("b_ovf", b_ovf_err, 0);
        chk("rd_while_empty", uf, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
